// File: rtl/sprite_render_frog.sv
// Frog sprite renderer: maps screen pixels to sprite RAM addresses,
// absorbs the RAM's one-cycle read latency, applies facing rotation and
// transparency keying, and emits a pixel-aligned RGB333 colour with hit flag.
module sprite_render_frog #(
    parameter int          SPR_SIZE = 32,
    parameter logic [8:0]  TRANSP   = 9'b111_000_111
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          frame_start,
    input  logic [9:0]                    frog_x,
    input  logic [9:0]                    frog_y,
    input  logic [1:0]                    frog_dir,
    input  logic                          frog_en,
    input  logic [9:0]                    pix_x,
    input  logic [9:0]                    pix_y,
    input  logic                          pix_valid,
    output logic [2*$clog2(SPR_SIZE)-1:0] addr,
    input  logic [8:0]                    data_in,
    output logic [8:0]                    pix_rgb,
    output logic                          pix_hit,
    output logic                          pix_valid_o
);

    // Sprite coordinate width; SPR_SIZE must be a power of two below 1024.
    localparam int            AW   = $clog2(SPR_SIZE);
    localparam logic [AW-1:0] MAXC = AW'(SPR_SIZE - 1);

    // Facing rotation: returns {row, col} for sprite-local (u, v).
    function automatic logic [2*AW-1:0] rot_addr(input logic [1:0] dir,
                                                 input logic [AW-1:0] u,
                                                 input logic [AW-1:0] v);
        logic [2*AW-1:0] r;
        case (dir)
            2'd0:    r = {v, u};
            2'd1:    r = {MAXC - u, v};
            2'd2:    r = {MAXC - v, MAXC - u};
            default: r = {u, MAXC - v};
        endcase
        return r;
    endfunction

    logic [9:0] shadow_x;
    logic [9:0] shadow_y;
    logic [1:0] shadow_dir;
    logic       shadow_en;

    logic signed [10:0] dx_p0;
    logic signed [10:0] dy_p0;
    logic               in_p0;
    logic [2*AW-1:0]    addr_p0;

    logic in_p1;
    logic vld_p1;
    logic hit_next;

    // Shadow latch: frog state only changes at the frame_start pulse, so
    // a frame is rendered from one consistent position/facing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_x   <= '0;
            shadow_y   <= '0;
            shadow_dir <= 2'd0;
            shadow_en  <= 1'b0;
        end else if (frame_start) begin
            shadow_x   <= frog_x;
            shadow_y   <= frog_y;
            shadow_dir <= frog_dir;
            shadow_en  <= frog_en;
        end
    end

    // ---- stage 0: window test and address generation ----
    // 11-bit subtraction keeps a sign bit, so pixels left of / above the
    // sprite never wrap around onto the sprite near the screen edge.
    always_comb begin
        dx_p0   = $signed({1'b0, pix_x}) - $signed({1'b0, shadow_x});
        dy_p0   = $signed({1'b0, pix_y}) - $signed({1'b0, shadow_y});
        in_p0   = pix_valid & shadow_en
                & ~dx_p0[10] & ~dy_p0[10]
                & (dx_p0[9:AW] == '0) & (dy_p0[9:AW] == '0);
        addr_p0 = rot_addr(shadow_dir, dx_p0[AW-1:0], dy_p0[AW-1:0]);
    end

    // ---- stage 1: registered RAM address, window flag and valid ----
    // The address only moves for in-window pixels to avoid needless RAM toggling.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr   <= '0;
            in_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (in_p0)
                addr <= addr_p0;
            in_p1  <= in_p0;
            vld_p1 <= pix_valid;
        end
    end

    // ---- stage 2: RAM data valid, colour keying ----
    assign hit_next = in_p1 & (data_in != TRANSP);

    // Output register: colour forced to zero wherever the sprite is not opaque.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pix_hit     <= 1'b0;
            pix_rgb     <= '0;
            pix_valid_o <= 1'b0;
        end else begin
            pix_hit     <= hit_next;
            pix_rgb     <= hit_next ? data_in : 9'd0;
            pix_valid_o <= vld_p1;
        end
    end

endmodule

// File: tb/tb_sprite_render_frog.sv
// Bench for sprite_render_frog: directed pixels with hand-computed
// expectations queued into a scoreboard, drained by a monitor process.
module tb_sprite_render_frog;

    localparam logic [8:0] TRANSP = 9'b111_000_111;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] frog_x = '0;
    logic [9:0] frog_y = '0;
    logic [1:0] frog_dir = '0;
    logic       frog_en = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       pix_valid = 1'b0;
    logic [9:0] addr;
    logic [8:0] data_in;
    logic [8:0] pix_rgb;
    logic       pix_hit;
    logic       pix_valid_o;

    logic [8:0] ram [0:1023];

    int checks = 0;
    int errors = 0;

    logic [9:0] sb[$];          // {hit, rgb}
    bit         pend = 0;
    logic [9:0] pend_exp = '0;
    string      pend_name = "";

    sprite_render_frog dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start),
        .frog_x(frog_x), .frog_y(frog_y), .frog_dir(frog_dir), .frog_en(frog_en),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .addr(addr), .data_in(data_in),
        .pix_rgb(pix_rgb), .pix_hit(pix_hit), .pix_valid_o(pix_valid_o)
    );

    // RAM returns the word for the registered address during the following cycle
    assign data_in = ram[addr];

    always #5 CLK = ~CLK;

    // Monitor: compare each valid output against the oldest queued expectation
    always @(negedge CLK) begin
        if (!RST) begin
            if (pix_valid_o) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got hit=%0b rgb=%0o, required no output", pix_hit, pix_rgb);
                end else begin
                    logic [9:0] e;
                    e = sb.pop_front();
                    if (pix_hit !== e[9] || pix_rgb !== e[8:0]) begin
                        errors++;
                        $display("FAIL pixel_out @%0t: got hit=%0b rgb=%0o, required hit=%0b rgb=%0o",
                                 $time, pix_hit, pix_rgb, e[9], e[8:0]);
                    end
                end
            end else begin
                checks++;
                if (pix_hit !== 1'b0 || pix_rgb !== 9'd0) begin
                    errors++;
                    $display("FAIL idle_out @%0t: got hit=%0b rgb=%0o, required 0/0", $time, pix_hit, pix_rgb);
                end
            end
        end
    end

    // Drive one pixel cycle; optionally check the address one edge later
    task automatic drive(input int x, input int y, input bit valid, input bit fs,
                         input bit eh, input logic [8:0] er,
                         input bit ca, input int ea, input string nm);
        @(negedge CLK);
        if (pend) begin
            checks++;
            if (addr !== pend_exp) begin
                errors++;
                $display("FAIL %s: got addr=%0d, required %0d", pend_name, addr, pend_exp);
            end
            pend = 0;
        end
        pix_x       = x[9:0];
        pix_y       = y[9:0];
        pix_valid   = valid;
        frame_start = fs;
        if (valid) sb.push_back({eh, er});
        if (ca) begin
            pend      = 1;
            pend_exp  = ea[9:0];
            pend_name = nm;
        end
    endtask

    task automatic set_frog(input int x, input int y, input logic [1:0] d, input bit en);
        frog_x   = x[9:0];
        frog_y   = y[9:0];
        frog_dir = d;
        frog_en  = en;
        drive(0, 0, 0, 1, 0, 9'd0, 0, 0, "");
        drive(0, 0, 0, 0, 0, 9'd0, 0, 0, "");
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (addr !== 10'd0 || pix_rgb !== 9'd0 || pix_hit !== 1'b0 || pix_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got addr=%0d rgb=%0o hit=%0b vo=%0b, required all 0",
                     nm, addr, pix_rgb, pix_hit, pix_valid_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 9'o001;
        ram[0]    = 9'o123;
        ram[1023] = 9'o777;
        ram[5]    = TRANSP;
        ram[901]  = 9'o045;
        ram[860]  = 9'o056;
        ram[122]  = 9'o067;

        repeat (2) @(negedge CLK);
        check_zero("reset_state");
        RST = 1'b0;

        // Basic UP mapping, corners and misses
        set_frog(100, 50, 2'd0, 1);
        drive(100, 50, 1, 0, 1, 9'o123, 1, 0,    "addr_origin");
        drive(131, 81, 1, 0, 1, 9'o777, 1, 1023, "addr_corner");
        drive(132, 81, 1, 0, 0, 9'd0,   1, 1023, "addr_hold_miss");
        drive(99,  50, 1, 0, 0, 9'd0,   0, 0,    "");
        drive(105, 50, 1, 0, 0, 9'd0,   1, 5,    "addr_transp");
        drive(101, 50, 1, 0, 1, 9'o001, 1, 1,    "addr_col1");
        drive(110, 60, 0, 0, 0, 9'd0,   1, 1,    "addr_hold_invalid");

        // Rotations
        set_frog(100, 50, 2'd1, 1);
        drive(103, 55, 1, 0, 1, 9'o045, 1, 901, "addr_right");
        set_frog(100, 50, 2'd2, 1);
        drive(103, 55, 1, 0, 1, 9'o056, 1, 860, "addr_down");
        set_frog(100, 50, 2'd3, 1);
        drive(103, 55, 1, 0, 1, 9'o067, 1, 122, "addr_left");

        // Sprite disabled for the frame
        set_frog(100, 50, 2'd0, 0);
        drive(100, 50, 1, 0, 0, 9'd0, 0, 0, "");
        drive(110, 60, 1, 0, 0, 9'd0, 0, 0, "");

        // Shadow latching and frame_start coincidence
        set_frog(100, 50, 2'd0, 1);
        frog_x = 10'd200;
        drive(100, 50, 1, 0, 1, 9'o123, 0, 0, "");
        drive(200, 50, 1, 0, 0, 9'd0,   0, 0, "");
        drive(100, 50, 1, 1, 1, 9'o123, 0, 0, "");
        drive(200, 50, 1, 0, 1, 9'o123, 1, 0, "addr_after_latch");
        drive(100, 50, 1, 0, 0, 9'd0,   0, 0, "");

        // Right screen edge
        set_frog(620, 0, 2'd0, 1);
        drive(620,  0, 1, 0, 1, 9'o123, 1, 0,  "addr_edge_left");
        drive(639,  0, 1, 0, 1, 9'o001, 1, 19, "addr_edge_right");
        drive(0,    0, 1, 0, 0, 9'd0,   1, 19, "addr_edge_wrap_hold");
        drive(651,  0, 1, 0, 1, 9'o001, 1, 31, "addr_edge_last");
        drive(652,  0, 1, 0, 0, 9'd0,   0, 0,  "");
        set_frog(1000, 0, 2'd0, 1);
        drive(1023, 0, 1, 0, 1, 9'o001, 1, 23, "addr_x1023");
        drive(0,    0, 1, 0, 0, 9'd0,   1, 23, "addr_no_alias");
        drive(0,    0, 0, 0, 0, 9'd0,   0, 0,  "");
        repeat (3) @(negedge CLK);

        // Reset mid-line
        set_frog(620, 0, 2'd0, 1);
        drive(630, 0, 1, 0, 1, 9'o001, 0, 0, "");
        drive(631, 0, 1, 0, 1, 9'o001, 0, 0, "");
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 check_zero("reset_midline");
        sb.delete();
        pend = 0;
        pix_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        drive(620, 0, 1, 0, 0, 9'd0, 0, 0, "");
        drive(0, 0, 0, 0, 0, 9'd0, 0, 0, "");
        set_frog(620, 0, 2'd0, 1);
        drive(620, 0, 1, 0, 1, 9'o123, 1, 0, "addr_after_reset");
        drive(0, 0, 0, 0, 0, 9'd0, 0, 0, "");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
